// File: rtl/i2c_bus_filter.sv
// SCL/SDA pad conditioner: 2-flop sync, spike filter, edge/START/STOP strobes, bus-busy flag.
// Latency: pad change reaches scl_o/sda_o after FILT_CYC+2 clks; strobes appear in that same clk.
// No backpressure: strobes last one clk and the consumer must sample them on every clk.
module i2c_bus_filter #(
    parameter int CLK_FREQ = 100,
    parameter int SPIKE_NS = 50,
    parameter int IDLE_US  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam int FILT_RAW = (CLK_FREQ * SPIKE_NS) / 1000;
    localparam int FILT_CYC = (FILT_RAW < 1) ? 1 : FILT_RAW;
    localparam int IDLE_CYC = CLK_FREQ * IDLE_US;
    localparam int FW       = $clog2(FILT_CYC + 1);
    localparam int IW       = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

    localparam logic [FW-1:0] FILT_LAST  = FW'(FILT_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYC);
    localparam bit            TIMEOUT_EN = (IDLE_US != 0);

    // Bit 0 carries SCL, bit 1 carries SDA throughout.
    logic [1:0]         s1_q, s1_d;
    logic [1:0]         s2_q, s2_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         dly_q, dly_d;
    logic [1:0][FW-1:0] cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic               busy_q, busy_d;
    logic               strb_ok;
    logic               idle_full;

    always_comb begin
        s1_d  = {sda_pad_i, scl_pad_i};
        s2_d  = s1_q;
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (!en) begin
                lvl_d[i] = 1'b1;
            end else if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        dly_d = en ? lvl_q : 2'b11;
        en_d  = en;
    end

    // Strobes are suppressed while disabled and in the clk right after enable.
    always_comb begin
        strb_ok   = en & en_q;
        scl_rise  = strb_ok &  lvl_q[0] & ~dly_q[0];
        scl_fall  = strb_ok & ~lvl_q[0] &  dly_q[0];
        start_det = strb_ok & lvl_q[0] & dly_q[0] &  dly_q[1] & ~lvl_q[1];
        stop_det  = strb_ok & lvl_q[0] & dly_q[0] & ~dly_q[1] &  lvl_q[1];

        idle_d = '0;
        if (&lvl_q) begin
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
        end
        idle_full = TIMEOUT_EN && (idle_d == IDLE_MAX);

        busy_d = busy_q;
        if (!en) begin
            busy_d = 1'b0;
        end else if (start_det) begin
            busy_d = 1'b1;
        end else if (stop_det || idle_full) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            lvl_q  <= 2'b11;
            dly_q  <= 2'b11;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            idle_q <= '0;
            busy_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            dly_q  <= dly_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            idle_q <= idle_d;
            busy_q <= busy_d;
        end
    end

    assign scl_o    = lvl_q[0];
    assign sda_o    = lvl_q[1];
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Bench for i2c_bus_filter: vector table, directed corner sequences and random pads vs a run-length model.
module tb_i2c_bus_filter;

    localparam int F    = 5;
    localparam int IDLE = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic scl_pad = 1'b1;
    logic sda_pad = 1'b1;
    logic scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy;

    always #5 clk = ~clk;

    i2c_bus_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scl_pad_i (scl_pad),
        .sda_pad_i (sda_pad),
        .scl_o     (scl_o),
        .sda_o     (sda_o),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .bus_busy  (bus_busy)
    );

    int total = 0;
    int bad   = 0;
    int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;

    always @(negedge clk) begin
        if (scl_rise)  n_rise++;
        if (scl_fall)  n_fall++;
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
    end

    // Reference model: a line's level follows the synchronised pad once that pad
    // value has been seen on F consecutive enabled clks.
    logic [1:0] m_lvl, m_prev, m_s2;
    logic [3:0] m_s;
    logic       m_en_q, m_busy;
    logic [1:0] hist[$];
    int         m_run_len[2];
    logic       m_run_val[2];
    int         m_idle;

    function automatic logic [3:0] strobes(input logic [1:0] lvl, input logic [1:0] prev,
                                           input logic e, input logic eq);
        logic [3:0] s;
        s = '0;
        if (e && eq) begin
            s[3] =  lvl[0] && !prev[0];
            s[2] = !lvl[0] &&  prev[0];
            s[1] =  lvl[0] &&  prev[0] &&  prev[1] && !lvl[1];
            s[0] =  lvl[0] &&  prev[0] && !prev[1] &&  lvl[1];
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lvl = 2'b11;
            m_prev = 2'b11;
            m_en_q = 1'b0;
            m_busy = 1'b0;
            m_idle = 0;
            hist = '{2'b11, 2'b11};
            m_run_len = '{0, 0};
            m_run_val = '{1'b1, 1'b1};
        end else begin
            m_s = strobes(m_lvl, m_prev, en, m_en_q);
            m_idle = (m_lvl == 2'b11) ? m_idle + 1 : 0;
            if (!en)                m_busy = 1'b0;
            else if (m_s[1])        m_busy = 1'b1;
            else if (m_s[0])        m_busy = 1'b0;
            else if (m_idle >= IDLE) m_busy = 1'b0;
            m_prev = en ? m_lvl : 2'b11;
            m_s2 = hist.pop_front();
            hist.push_back({sda_pad, scl_pad});
            for (int i = 0; i < 2; i++) begin
                if (!en) begin
                    m_lvl[i] = 1'b1;
                    m_run_len[i] = 0;
                end else begin
                    if (m_run_len[i] > 0 && m_s2[i] == m_run_val[i]) begin
                        m_run_len[i]++;
                    end else begin
                        m_run_val[i] = m_s2[i];
                        m_run_len[i] = 1;
                    end
                    if (m_run_len[i] >= F && m_run_val[i] != m_lvl[i]) m_lvl[i] = m_run_val[i];
                end
            end
            m_en_q = en;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        logic [6:0] e_v, a_v;
        @(posedge clk);
        #1;
        e_v = {m_lvl[0], m_lvl[1], strobes(m_lvl, m_prev, en, m_en_q), m_busy};
        a_v = {scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy};
        total++;
        if (a_v !== e_v) begin
            bad++;
            $display("FAIL model_cmp actual=%b required=%b t=%0t", a_v, e_v, $time);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic scl, sda, en;
        int   hold;
        logic e_scl, e_sda, e_busy;
        int   e_start, e_stop;
    } vec_t;

    vec_t vt[12];
    int   r0, f0, st0, sp0;
    bit   found;

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0, 0, 0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b1, 1, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b1, 0, 0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b1, 1'b1, 0, 0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b1, 0, 0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b1, 1, 0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0, 0, 1};
        vt[7]  = '{1'b1, 1'b0, 1'b1,  3, 1'b1, 1'b1, 1'b0, 0, 0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0, 0, 0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 0, 0};
        vt[10] = '{1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0, 0, 0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0, 0, 0};

        // Reset and quiet bus after release
        steps(3);
        check("rst_levels", {scl_o, sda_o}, 2'b11);
        check("rst_busy", bus_busy, 0);
        rst_n = 1'b1;
        r0 = n_rise + n_fall + n_start + n_stop;
        steps(100);
        check("idle_no_strobes", n_rise + n_fall + n_start + n_stop - r0, 0);
        check("idle_levels", {scl_o, sda_o}, 2'b11);

        for (int k = 0; k < 12; k++) begin
            scl_pad = vt[k].scl;
            sda_pad = vt[k].sda;
            en      = vt[k].en;
            st0 = n_start;
            sp0 = n_stop;
            steps(vt[k].hold);
            check($sformatf("vec%0d_scl", k), scl_o, vt[k].e_scl);
            check($sformatf("vec%0d_sda", k), sda_o, vt[k].e_sda);
            check($sformatf("vec%0d_busy", k), bus_busy, vt[k].e_busy);
            check($sformatf("vec%0d_starts", k), n_start - st0, vt[k].e_start);
            check($sformatf("vec%0d_stops", k), n_stop - sp0, vt[k].e_stop);
        end

        // START latency: level falls exactly F+2 clks after the pad
        sda_pad = 1'b0;
        steps(F + 1);
        check("start_sda_before", sda_o, 1);
        step();
        check("start_sda_after", sda_o, 0);
        check("start_pulse", start_det, 1);
        check("start_busy_same", bus_busy, 0);
        step();
        check("start_pulse_end", start_det, 0);
        check("start_busy_next", bus_busy, 1);
        steps(12);

        // Full byte plus ACK, then STOP
        r0 = n_rise; f0 = n_fall; st0 = n_start;
        for (int b = 0; b < 9; b++) begin
            scl_pad = 1'b0;
            steps(20);
            sda_pad = (b == 8) ? 1'b0 : 1'($urandom_range(0, 1));
            steps(20);
            scl_pad = 1'b1;
            steps(40);
        end
        check("byte_rises", n_rise - r0, 9);
        check("byte_falls", n_fall - f0, 9);
        check("byte_no_start", n_start - st0, 0);
        sp0 = n_stop;
        sda_pad = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (stop_det) begin
                found = 1'b1;
                check("stop_busy_same", bus_busy, 1);
                step();
                check("stop_busy_after", bus_busy, 0);
            end
        end
        check("stop_seen", found, 1);
        steps(5);
        check("stop_count", n_stop - sp0, 1);

        // Timeout with both lines returning high on the same clk
        sda_pad = 1'b0;
        steps(20);
        scl_pad = 1'b0;
        steps(20);
        check("to_busy_set", bus_busy, 1);
        st0 = n_start; sp0 = n_stop;
        scl_pad = 1'b1;
        sda_pad = 1'b1;
        steps(20);
        check("same_clk_no_start", n_start - st0, 0);
        check("same_clk_no_stop", n_stop - sp0, 0);
        check("to_busy_held", bus_busy, 1);
        steps(IDLE - 20);
        check("to_busy_before", bus_busy, 1);
        steps(10);
        check("to_busy_cleared", bus_busy, 0);

        // Disable while busy
        sda_pad = 1'b0;
        steps(20);
        check("dis_busy_set", bus_busy, 1);
        en = 1'b0;
        step();
        check("dis_busy", bus_busy, 0);
        check("dis_levels", {scl_o, sda_o}, 2'b11);
        sda_pad = 1'b1;
        steps(5);
        en = 1'b1;
        r0 = n_rise + n_fall + n_start + n_stop;
        steps(30);
        check("dis_release_quiet", n_rise + n_fall + n_start + n_stop - r0, 0);

        // Async reset mid-byte
        sda_pad = 1'b0;
        steps(20);
        scl_pad = 1'b0;
        steps(20);
        check("rst_mid_pre", {scl_o, sda_o, bus_busy}, 3'b001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_levels", {scl_o, sda_o}, 2'b11);
        check("rst_mid_busy", bus_busy, 0);
        check("rst_mid_strobes", {scl_rise, scl_fall, start_det, stop_det}, 4'b0000);
        scl_pad = 1'b1;
        sda_pad = 1'b1;
        steps(3);
        rst_n = 1'b1;
        r0 = n_rise + n_fall + n_start + n_stop;
        steps(30);
        check("rst_release_quiet", n_rise + n_fall + n_start + n_stop - r0, 0);
        check("rst_release_busy", bus_busy, 0);

        // Random pads and enable against the model
        for (int c = 0; c < 4000; c++) begin
            int rate;
            rate = ((c / 500) % 2) ? 14 : 4;
            if ($urandom_range(0, rate) == 0) scl_pad = ~scl_pad;
            if ($urandom_range(0, rate) == 0) sda_pad = ~sda_pad;
            if ($urandom_range(0, 79) == 0) en = ~en;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
